// File: rtl/drops_button_receiver.sv
// Player-control receiver for the drops game: synchronises and debounces the
// up/down buttons, then produces clean levels, press strobes and auto-repeat.
module drops_button_receiver #(
   parameter int unsigned DB_CYCLES = 1000,
   parameter int unsigned REP_DELAY = 250000,
   parameter int unsigned REP_RATE  = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_i,
   input  logic btn_down_i,
   output logic up_level_o,
   output logic down_level_o,
   output logic up_pulse_o,
   output logic down_pulse_o,
   output logic conflict_o
);

   localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
   localparam int unsigned REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   // Bit 0 is the up button, bit 1 the down button throughout.
   logic [1:0]            sync1;
   logic [1:0]            sync2;
   logic [1:0]            level;
   logic [1:0]            level_nxt;
   logic [1:0][DB_W-1:0]  db_cnt;
   logic [1:0][DB_W-1:0]  db_cnt_nxt;
   logic [1:0][REP_W-1:0] rep_cnt;
   logic [1:0][REP_W-1:0] rep_cnt_nxt;
   logic [1:0]            rep_first;
   logic [1:0]            rep_first_nxt;
   logic [1:0]            press;
   logic [1:0]            rep_fire;
   logic [1:0]            strobe;
   logic [1:0]            pulse_nxt;

   // Two-flop synchroniser for the asynchronous button pads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {btn_down_i, btn_up_i};
         sync2 <= sync1;
      end
   end

   // Debounce: level flips only after DB_CYCLES consecutive differing samples.
   always_comb begin
      level_nxt  = level;
      db_cnt_nxt = db_cnt;
      for (int b = 0; b < 2; b++) begin
         if (sync2[b] == level[b]) begin
            db_cnt_nxt[b] = '0;
         end else if (db_cnt[b] == DB_W'(DB_CYCLES - 1)) begin
            level_nxt[b]  = ~level[b];
            db_cnt_nxt[b] = '0;
         end else begin
            db_cnt_nxt[b] = db_cnt[b] + DB_W'(1);
         end
      end
      press = level_nxt & ~level;
   end

   // Auto-repeat timing; held at zero while released or while both buttons are down.
   always_comb begin
      rep_cnt_nxt   = rep_cnt;
      rep_first_nxt = rep_first;
      rep_fire      = '0;
      for (int b = 0; b < 2; b++) begin
         if ((REP_DELAY == 0) || !level[b] || conflict_o) begin
            rep_cnt_nxt[b]   = '0;
            rep_first_nxt[b] = 1'b1;
         end else if (rep_cnt[b] == (rep_first[b] ? REP_W'(REP_DELAY - 1)
                                                  : REP_W'(REP_RATE - 1))) begin
            // A repeat coinciding with the release edge is dropped.
            rep_fire[b]      = level_nxt[b];
            rep_cnt_nxt[b]   = '0;
            rep_first_nxt[b] = 1'b0;
         end else begin
            rep_cnt_nxt[b] = rep_cnt[b] + REP_W'(1);
         end
      end
   end

   // Merge press and repeat strobes; coincident up/down strobes cancel each other.
   always_comb begin
      strobe    = press | rep_fire;
      pulse_nxt = (&strobe) ? 2'b00 : strobe;
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level        <= '0;
         db_cnt       <= '0;
         rep_cnt      <= '0;
         rep_first    <= '1;
         conflict_o   <= 1'b0;
         up_pulse_o   <= 1'b0;
         down_pulse_o <= 1'b0;
      end else begin
         level        <= level_nxt;
         db_cnt       <= db_cnt_nxt;
         rep_cnt      <= rep_cnt_nxt;
         rep_first    <= rep_first_nxt;
         conflict_o   <= &level_nxt;
         up_pulse_o   <= pulse_nxt[0];
         down_pulse_o <= pulse_nxt[1];
      end
   end

   assign up_level_o   = level[0];
   assign down_level_o = level[1];

endmodule
